// File: rtl/ula_lo_seq_if.sv
// Handshake and operand/result bundle for the sequential logic/shift unit.
interface ula_lo_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       OP;
  logic [SHW-1:0]   SHAMT;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] RESU;
  logic             O;
  logic             C;
  logic             S;
  logic             Z;

  modport master (
    output start, A, B, OP, SHAMT,
    input  busy, done, err, RESU, O, C, S, Z
  );

  modport slave (
    input  start, A, B, OP, SHAMT,
    output busy, done, err, RESU, O, C, S, Z
  );
endinterface

// File: rtl/ula_lo_seq.sv
// Sequential WIDTH-bit logic/shift unit with start/done handshake and registered flags.
// Define ULA_LO_BARREL_EN for single-cycle barrel shifts; otherwise shifts step one bit per cycle.
module ula_lo_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         reset,
  ula_lo_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

`ifdef ULA_LO_BARREL_EN
  localparam bit ITER = 1'b0;
`else
  localparam bit ITER = 1'b1;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       shop_q;
  logic             amsb_q;

  logic [WIDTH-1:0] resu_q;
  logic             o_q, c_q, s_q, z_q;
  logic             busy_q, done_q, err_q;

  logic             in_shift;
  logic             load, step, commit;
  logic [4:0]       cop;
  logic             a_msb;
  logic             legal;
  logic [WIDTH-1:0] step_res, in_res, sh_res, lres;
  logic             step_c, in_c, sh_c;
  logic [WIDTH-1:0] res_d;
  logic             o_d, c_d, s_d, z_d;

  // Bitwise logic table indexed by the low four opcode bits.
  function automatic logic [WIDTH-1:0] logic_res(input logic [3:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      4'h0:    r = '0;
      4'h1:    r = a & b;
      4'h2:    r = ~a & b;
      4'h3:    r = b;
      4'h4:    r = a & ~b;
      4'h5:    r = a;
      4'h6:    r = a ^ b;
      4'h7:    r = a | b;
      4'h8:    r = ~a & ~b;
      4'h9:    r = ~(a ^ b);
      4'hA:    r = ~a;
      4'hB:    r = ~a | b;
      4'hC:    r = ~b;
      4'hD:    r = a | ~b;
      4'hE:    r = ~a | ~b;
      default: r = WIDTH'(1);
    endcase
    return r;
  endfunction

  assign in_shift = (bus.OP[4:2] == 3'b010);

  // Next-state and control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (ITER && in_shift && (bus.SHAMT != '0)) begin
            state_d = SHIFT;
            load    = 1'b1;
          end else begin
            state_d = FIN;
            commit  = 1'b1;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d = FIN;
          commit  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One 1-bit step of the latched shift op; the bit leaving the word becomes the carry.
  always_comb begin
    step_res = work_q;
    step_c   = 1'b0;
    case (shop_q)
      2'b00: begin
        step_res = {work_q[WIDTH-2:0], 1'b0};
        step_c   = work_q[WIDTH-1];
      end
      2'b01: begin
        step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_c   = work_q[0];
      end
      2'b10: begin
        step_res = {1'b0, work_q[WIDTH-1:1]};
        step_c   = work_q[0];
      end
      default: begin
        step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        step_c   = work_q[WIDTH-1];
      end
    endcase
  end

`ifdef ULA_LO_BARREL_EN
  logic [WIDTH:0]     lsl_w, lsr_w, asr_w;
  logic [2*WIDTH-1:0] rol_w;

  // Extra guard bit on each side captures the last bit shifted out.
  always_comb begin
    lsl_w  = {1'b0, bus.A} << bus.SHAMT;
    lsr_w  = {bus.A, 1'b0} >> bus.SHAMT;
    asr_w  = $signed({bus.A, 1'b0}) >>> bus.SHAMT;
    rol_w  = {bus.A, bus.A} << bus.SHAMT;
    in_res = bus.A;
    in_c   = 1'b0;
    case (bus.OP[1:0])
      2'b00: begin
        in_res = lsl_w[WIDTH-1:0];
        in_c   = lsl_w[WIDTH];
      end
      2'b01: begin
        in_res = asr_w[WIDTH:1];
        in_c   = asr_w[0];
      end
      2'b10: begin
        in_res = lsr_w[WIDTH:1];
        in_c   = lsr_w[0];
      end
      default: begin
        in_res = rol_w[2*WIDTH-1:WIDTH];
        in_c   = (bus.SHAMT != '0) & rol_w[WIDTH];
      end
    endcase
  end
`else
  // Only zero-count shifts complete straight from IDLE.
  assign in_res = bus.A;
  assign in_c   = 1'b0;
`endif

  // Result and flag values written on the commit edge; unaffected flags hold.
  always_comb begin
    cop    = (state_q == IDLE) ? bus.OP : {3'b010, shop_q};
    a_msb  = (state_q == IDLE) ? bus.A[WIDTH-1] : amsb_q;
    sh_res = (state_q == IDLE) ? in_res : step_res;
    sh_c   = (state_q == IDLE) ? in_c : step_c;
    lres   = logic_res(bus.OP[3:0], bus.A, bus.B);
    legal  = cop[4] | (cop[4:2] == 3'b010);
    res_d  = resu_q;
    o_d    = o_q;
    c_d    = c_q;
    s_d    = s_q;
    z_d    = z_q;
    if (cop[4]) begin
      res_d = lres;
      if ((cop != 5'b10011) && (cop != 5'b11111)) begin
        z_d = (lres == '0);
        if (cop != 5'b10000) s_d = lres[WIDTH-1];
      end
    end else if (cop[4:2] == 3'b010) begin
      res_d = sh_res;
      c_d   = sh_c;
      z_d   = (sh_res == '0);
      s_d   = sh_res[WIDTH-1];
      o_d   = ((cop[1:0] == 2'b00) || (cop[1:0] == 2'b11)) ? (sh_res[WIDTH-1] != a_msb) : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      shop_q <= '0;
      amsb_q <= 1'b0;
      resu_q <= '0;
      o_q    <= 1'b0;
      c_q    <= 1'b0;
      s_q    <= 1'b0;
      z_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == SHIFT);
      done_q <= commit;
      err_q  <= commit & ~legal;
      if (load) begin
        work_q <= bus.A;
        cnt_q  <= bus.SHAMT;
        shop_q <= bus.OP[1:0];
        amsb_q <= bus.A[WIDTH-1];
      end else if (step) begin
        work_q <= step_res;
        cnt_q  <= cnt_q - SHW'(1);
      end
      if (commit) begin
        resu_q <= res_d;
        o_q    <= o_d;
        c_q    <= c_d;
        s_q    <= s_d;
        z_q    <= z_d;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.RESU = resu_q;
  assign bus.O    = o_q;
  assign bus.C    = c_q;
  assign bus.S    = s_q;
  assign bus.Z    = z_q;

endmodule

// File: doc/ula_lo_seq.md
# ula_lo_seq

Parametrised, sequential successor to the 3-bit logic ALU. It performs the same 5-bit-opcode logic operations on WIDTH-bit operands and adds multi-bit shifts and rotates driven by a shift amount. It uses a start/done handshake with registered result and flags. It sits beside the arithmetic unit in the datapath: the control unit issues one operation, waits for `done`, then reads `RESU` and the flags.

## Interface
- `WIDTH`, 16, operand/result width (≥ 4)
- `SHW`, `$clog2(WIDTH)`, width of the shift-amount port
- `clk` in 1, single clock, all state updates on rising edge
- `reset` in 1, asynchronous, active-high reset
- `start` in 1, request; sampled only while `busy`=0
- `A` in WIDTH, operand A (shifted operand for shift ops)
- `B` in WIDTH, operand B
- `OP` in 5, opcode
- `SHAMT` in SHW, shift/rotate count, 0..WIDTH-1
- `busy` out 1, high from the cycle after acceptance until `done`
- `done` out 1, one-cycle pulse; `RESU` and flags valid from this cycle
- `err` out 1, high with `done` when `OP` was illegal
- `RESU` out WIDTH, registered result
- `O`, `C`, `S`, `Z` out 1 each, registered overflow, carry, sign and zero flags

## Operation
- FSM states: IDLE, SHIFT, FIN.
  - IDLE + `start` → latch `A`, `B`, `OP` and `SHAMT`.
  - Shift op with `SHAMT`>0 → SHIFT. Otherwise → FIN.
  - SHIFT performs one 1-bit step per cycle. After `SHAMT` steps → FIN.
  - FIN pulses `done` → IDLE.
- Shift ops:
  - 01000 LSL: zero fill.
  - 01001 ASR: sign fill.
  - 01010 LSR: zero fill.
  - 01011 ROL.
- Logic ops (results are bitwise over WIDTH bits):
  - 10000 → 0; 10001 A&B; 10010 ~A&B; 10011 B; 10100 A&~B; 10101 A; 10110 A^B; 10111 A|B.
  - 11000 ~A&~B; 11001 ~(A^B); 11010 ~A; 11011 ~A|B; 11100 ~B; 11101 A|~B; 11110 ~A|~B.
  - 11111 → 1, zero-extended.
- Any other `OP` is illegal: `RESU` and all flags hold, `err`=1 with `done`.
- Flag rules:
  - `Z` = (RESU==0) and `S` = RESU[WIDTH-1] for every legal op except 10011 and 11111, which leave `Z` and `S` unchanged.
  - 10000 updates `Z` (=1) but leaves `S` unchanged.
  - `C`:
    - LSL, ASR, LSR: `C` = last bit shifted out.
    - ROL: `C` = final RESU[0].
    - `SHAMT`=0: `C`=0.
    - Logic ops leave `C` unchanged.
  - `O`:
    - LSL and ROL: `O` = (RESU[WIDTH-1] != A[WIDTH-1]).
    - ASR and LSR: `O`=0.
    - Logic ops leave `O` unchanged.
- A shift with `SHAMT`=0 gives `RESU`=A.
- `start` while `busy`=1 is ignored. Inputs may change freely after acceptance.

## Timing
- Reset values: state IDLE; `RESU`=0; `O`=`C`=`S`=`Z`=0; `busy`=`done`=`err`=0.
- Accept at edge n.
  - Logic ops, illegal ops and zero-count shifts: `done` in cycle n+1.
  - Shifts: `done` in cycle n+1+SHAMT.
- `busy`=1 in cycles n+1 .. done-1. `busy` is low in the `done` cycle.
- `start` in the `done` cycle is not accepted; the next accept is in the first cycle after `done`, so back-to-back throughput is one op per latency+1 cycles.
- `RESU` and flags change only in the `done` cycle. They hold until the next `done`.
- `reset` mid-operation aborts immediately: no `done` is produced and all outputs take their reset values.

## Configuration
- `ULA_LO_BARREL_EN` defined: shifts use a single-cycle barrel shifter. Every op, including shifts, completes with `done` at n+1, and the SHIFT state is unused.
- Undefined: iterative 1-bit-per-cycle shifter as described above.
- Results and flags are bit-identical in both builds.

## Test plan
- Reset then WIDTH=16, OP=10110, A=16'hF0F0, B=16'hFF00, start → `done` at n+1; RESU=16'h0FF0, Z=0, S=0, C and O unchanged.
- OP=01001 (ASR), A=16'h8004, SHAMT=3 → `done` at n+4 (n+1 if barrel); RESU=16'hF000, C=1, S=1, O=0.
- OP=01000 (LSL), A=16'h4001, SHAMT=1 → RESU=16'h8002, C=0, O=1, S=1; follow with OP=10011, B=0 → RESU=0, Z and S unchanged.
- OP=00111 (illegal) → `done`+`err` at n+1, RESU and flags unchanged. Separately, `start` pulsed while `busy` → no extra `done`.
- Start LSL with SHAMT=15, assert `reset` at cycle n+5 → all outputs 0 immediately, no `done`. After release, OP=10000 → RESU=0, Z=1.
